// File: rtl/excp_pkg.sv
// Shared types and constants for the exception/ERET flush sequencer.
package excp_pkg;

  // Sequencer states: waiting, holding the pipeline flushed, issuing the PC load.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // Flush masks ordered {MEM, EXE, DEC, IF}: squash the faulting stage and everything younger.
  localparam logic [3:0] FLUSH_MASK_MEM  = 4'b1111;
  localparam logic [3:0] FLUSH_MASK_EXE  = 4'b0111;
  localparam logic [3:0] FLUSH_MASK_DEC  = 4'b0011;
  localparam logic [3:0] FLUSH_MASK_NONE = 4'b0000;
  localparam logic [3:0] FLUSH_MASK_IF   = 4'b0001;

  // Width of the dropped-exception counter.
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/excp_prio_enc.sv
// Oldest-wins priority encoder: MEM beats EXE beats DEC. Produces the one-hot
// qualified stage vector {MEM,EXE,DEC} and the matching flush mask.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic       dec_raw,
  input  logic       exe_raw,
  input  logic       mem_raw,
  input  logic       en,
  output logic [2:0] stage_excp,
  output logic [3:0] flush_mask
);

  // Nothing is qualified unless the sequencer is able to accept an exception.
  always_comb begin
    stage_excp = 3'b000;
    flush_mask = FLUSH_MASK_NONE;
    if (en) begin
      if (mem_raw) begin
        stage_excp = 3'b100;
        flush_mask = FLUSH_MASK_MEM;
      end else if (exe_raw) begin
        stage_excp = 3'b010;
        flush_mask = FLUSH_MASK_EXE;
      end else if (dec_raw) begin
        stage_excp = 3'b001;
        flush_mask = FLUSH_MASK_DEC;
      end
    end
  end

endmodule

// File: rtl/ffd.sv
// Generic D flop bank with synchronous active-high reset to zero and load enable.
module ffd #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins; otherwise load d only when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/excp_flush_ctrl.sv
// Exception/ERET sequencer feeding cp0: qualifies stage exceptions, flushes the
// pipeline for FLUSH_CYCLES cycles, then redirects the PC to the handler or EPC.
// Optional build macro EXCP_DROP_CNT_EN enables the saturating DROP_CNT counter;
// without it DROP_CNT reads zero.
module excp_flush_ctrl
  import excp_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  DEC_EXCP_RAW,
  input  logic                  EXE_EXCP_RAW,
  input  logic                  MEM_EXCP_RAW,
  input  logic                  ERET,
  input  logic [ADDR_W-1:0]     EPC,
  input  logic [ADDR_W-1:0]     EXCP_VECTOR,
  output logic                  DEC_STAGE_EXCP,
  output logic                  EXE_STAGE_EXCP,
  output logic                  MEM_STAGE_EXCP,
  output logic                  FLUSH_IF,
  output logic                  FLUSH_DEC,
  output logic                  FLUSH_EXE,
  output logic                  FLUSH_MEM,
  output logic                  PC_STALL,
  output logic                  PC_REDIRECT,
  output logic [ADDR_W-1:0]     PC_TARGET,
  output logic                  EXL,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  state_t            state;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              exl_q;
  logic              exl_d;
  logic              eret_q;
  logic              eret_d;
  logic [ADDR_W-1:0] target_q;
  logic [ADDR_W-1:0] target_d;
  logic              any_raw;
  logic              is_idle;
  logic              excp_ok;
  logic              eret_ok;
  logic [2:0]        stage_excp;
  logic [3:0]        prio_mask;
  logic [3:0]        flush;
  logic              stall;
  logic              redirect;

  assign state   = state_t'(state_q);
  assign any_raw = DEC_EXCP_RAW | EXE_EXCP_RAW | MEM_EXCP_RAW;
  assign is_idle = (state == IDLE);
  assign excp_ok = is_idle & ~exl_q & any_raw;
  // With EXL set any raw exception is masked, so a coincident ERET still goes through.
  assign eret_ok = is_idle & exl_q & ERET;

  excp_prio_enc u_prio (
    .dec_raw    (DEC_EXCP_RAW),
    .exe_raw    (EXE_EXCP_RAW),
    .mem_raw    (MEM_EXCP_RAW),
    .en         (excp_ok),
    .stage_excp (stage_excp),
    .flush_mask (prio_mask)
  );

  // Next-state and output decode for the accept / flush / redirect sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exl_d    = exl_q;
    eret_d   = eret_q;
    target_d = target_q;
    flush    = FLUSH_MASK_NONE;
    stall    = 1'b0;
    redirect = 1'b0;
    case (state)
      IDLE: begin
        if (excp_ok) begin
          flush    = prio_mask;
          state_d  = FLUSH;
          cnt_d    = FLUSH_LOAD;
          exl_d    = 1'b1;
          eret_d   = 1'b0;
          target_d = EXCP_VECTOR;
        end else if (eret_ok) begin
          flush    = FLUSH_MASK_MEM;
          state_d  = FLUSH;
          cnt_d    = FLUSH_LOAD;
          eret_d   = 1'b1;
          target_d = EPC;
        end
      end
      FLUSH: begin
        flush = FLUSH_MASK_MEM;
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        flush    = FLUSH_MASK_IF;
        redirect = 1'b1;
        state_d  = IDLE;
        if (eret_q) begin
          exl_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ffd #(.W(2))      u_state  (.clk(CLK), .reset(RESET), .en(1'b1), .d(state_d),  .q(state_q));
  ffd #(.W(4))      u_cnt    (.clk(CLK), .reset(RESET), .en(1'b1), .d(cnt_d),    .q(cnt_q));
  ffd #(.W(1))      u_exl    (.clk(CLK), .reset(RESET), .en(1'b1), .d(exl_d),    .q(exl_q));
  ffd #(.W(1))      u_eret   (.clk(CLK), .reset(RESET), .en(1'b1), .d(eret_d),   .q(eret_q));
  ffd #(.W(ADDR_W)) u_target (.clk(CLK), .reset(RESET), .en(1'b1), .d(target_d), .q(target_q));

  assign {MEM_STAGE_EXCP, EXE_STAGE_EXCP, DEC_STAGE_EXCP} = stage_excp;
  assign {FLUSH_MEM, FLUSH_EXE, FLUSH_DEC, FLUSH_IF}       = flush;
  assign PC_STALL    = stall;
  assign PC_REDIRECT = redirect;
  assign PC_TARGET   = target_q;
  assign EXL         = exl_q;

`ifdef EXCP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_q;
  logic [DROP_CNT_W-1:0] drop_d;
  logic                  drop_inc;

  // Count every cycle a raw request is present but not accepted; stick at all-ones.
  assign drop_inc = any_raw & ~excp_ok & (drop_q != {DROP_CNT_W{1'b1}});
  assign drop_d   = drop_q + 1'b1;

  ffd #(.W(DROP_CNT_W)) u_drop (.clk(CLK), .reset(RESET), .en(drop_inc), .d(drop_d), .q(drop_q));

  assign DROP_CNT = drop_q;
`else
  assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_excp_flush_ctrl.sv
// Directed bench for excp_flush_ctrl with FLUSH_CYCLES=2. Inputs change on the
// falling edge and outputs are sampled 1ns later, away from the rising edge.
module tb_excp_flush_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DEC_EXCP_RAW;
  logic        EXE_EXCP_RAW;
  logic        MEM_EXCP_RAW;
  logic        ERET;
  logic [31:0] EPC;
  logic [31:0] EXCP_VECTOR;
  logic        DEC_STAGE_EXCP;
  logic        EXE_STAGE_EXCP;
  logic        MEM_STAGE_EXCP;
  logic        FLUSH_IF;
  logic        FLUSH_DEC;
  logic        FLUSH_EXE;
  logic        FLUSH_MEM;
  logic        PC_STALL;
  logic        PC_REDIRECT;
  logic [31:0] PC_TARGET;
  logic        EXL;
  logic [15:0] DROP_CNT;

  int passed = 0;
  int failed = 0;
  int total  = 0;

`ifdef EXCP_DROP_CNT_EN
  localparam logic [31:0] DROP_ONE = 32'd1;
  localparam logic [31:0] DROP_TWO = 32'd2;
`else
  localparam logic [31:0] DROP_ONE = 32'd0;
  localparam logic [31:0] DROP_TWO = 32'd0;
`endif

  // Bit order: {DEC_X, EXE_X, MEM_X, F_IF, F_DEC, F_EXE, F_MEM, STALL, REDIR, EXL}
  logic [9:0] out_vec;
  assign out_vec = {DEC_STAGE_EXCP, EXE_STAGE_EXCP, MEM_STAGE_EXCP,
                    FLUSH_IF, FLUSH_DEC, FLUSH_EXE, FLUSH_MEM,
                    PC_STALL, PC_REDIRECT, EXL};

  excp_flush_ctrl #(.FLUSH_CYCLES(2), .ADDR_W(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .DEC_EXCP_RAW   (DEC_EXCP_RAW),
    .EXE_EXCP_RAW   (EXE_EXCP_RAW),
    .MEM_EXCP_RAW   (MEM_EXCP_RAW),
    .ERET           (ERET),
    .EPC            (EPC),
    .EXCP_VECTOR    (EXCP_VECTOR),
    .DEC_STAGE_EXCP (DEC_STAGE_EXCP),
    .EXE_STAGE_EXCP (EXE_STAGE_EXCP),
    .MEM_STAGE_EXCP (MEM_STAGE_EXCP),
    .FLUSH_IF       (FLUSH_IF),
    .FLUSH_DEC      (FLUSH_DEC),
    .FLUSH_EXE      (FLUSH_EXE),
    .FLUSH_MEM      (FLUSH_MEM),
    .PC_STALL       (PC_STALL),
    .PC_REDIRECT    (PC_REDIRECT),
    .PC_TARGET      (PC_TARGET),
    .EXL            (EXL),
    .DROP_CNT       (DROP_CNT)
  );

  // Free-running 10ns clock.
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic rst, input logic dec, input logic exe,
                               input logic mem, input logic eret,
                               input logic [31:0] epc, input logic [31:0] vec);
    @(negedge CLK);
    RESET        = rst;
    DEC_EXCP_RAW = dec;
    EXE_EXCP_RAW = exe;
    MEM_EXCP_RAW = mem;
    ERET         = eret;
    EPC          = epc;
    EXCP_VECTOR  = vec;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkVec(input string tag, input logic [9:0] exp);
    checkOutput(tag, {22'd0, out_vec}, {22'd0, exp});
  endtask

  // Linear directed sequence; each applyStimulus call is one clock cycle.
  initial begin
    RESET = 1'b1; DEC_EXCP_RAW = 1'b0; EXE_EXCP_RAW = 1'b0; MEM_EXCP_RAW = 1'b0;
    ERET = 1'b0; EPC = '0; EXCP_VECTOR = '0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("reset_outs", 10'b0000000000);
    checkOutput("reset_target", PC_TARGET, 32'h0);
    checkOutput("reset_drop", {16'd0, DROP_CNT}, 32'd0);

    $display("[TB] single EXE exception");
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0000DEAD);
    checkVec("exe_accept", 10'b0101110000);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("exe_flush1", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("exe_flush2", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("exe_redirect", 10'b0001000011);
    checkOutput("exe_target", PC_TARGET, 32'h0000DEAD);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("exe_idle_exl", 10'b0000000001);

    $display("[TB] drop while EXL set");
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);
    checkVec("exl_masked", 10'b0000000001);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("exl_masked_after", 10'b0000000001);
    checkOutput("drop_one", {16'd0, DROP_CNT}, DROP_ONE);

    $display("[TB] ERET with raw drop in flush");
    applyStimulus(0, 0, 0, 0, 1, 32'h00001234, 32'h0);
    checkVec("eret_accept", 10'b0001111001);
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0);
    checkVec("eret_flush1_raw", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("eret_flush2", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("eret_redirect", 10'b0001000011);
    checkOutput("eret_target", PC_TARGET, 32'h00001234);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("eret_exl_clear", 10'b0000000000);
    checkOutput("drop_two", {16'd0, DROP_CNT}, DROP_TWO);

    $display("[TB] all three raw, MEM wins");
    applyStimulus(0, 1, 1, 1, 0, 32'h0, 32'hBEEF0000);
    checkVec("mem_accept", 10'b0011111000);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("mem_flush1", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("mem_flush2", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("mem_redirect", 10'b0001000011);
    checkOutput("mem_target", PC_TARGET, 32'hBEEF0000);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("mem_idle_exl", 10'b0000000001);

    $display("[TB] reset during second flush cycle");
    applyStimulus(0, 0, 0, 0, 1, 32'h00005555, 32'h0);
    checkVec("rst_eret_accept", 10'b0001111001);
    checkOutput("rst_target_held", PC_TARGET, 32'hBEEF0000);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("rst_flush1", 10'b0001111101);
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("rst_flush2", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("rst_after", 10'b0000000000);
    checkOutput("rst_after_target", PC_TARGET, 32'h0);
    checkOutput("rst_after_drop", {16'd0, DROP_CNT}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      checkVec("rst_no_redirect", 10'b0000000000);
    end

    $display("[TB] ERET with EXL clear");
    applyStimulus(0, 0, 0, 0, 1, 32'h00007777, 32'h0);
    checkVec("eret_nop", 10'b0000000000);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
      checkVec("eret_nop_after", 10'b0000000000);
    end
    checkOutput("eret_nop_target", PC_TARGET, 32'h0);

    $display("[TB] single DEC exception");
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0000BEAD);
    checkVec("dec_accept", 10'b1001100000);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("dec_flush1", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("dec_flush2", 10'b0001111101);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("dec_redirect", 10'b0001000011);
    checkOutput("dec_target", PC_TARGET, 32'h0000BEAD);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkVec("dec_idle_exl", 10'b0000000001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
